// File: rtl/mips_boot_ctrl.sv
// mips_boot_ctrl
//   Boot and result-dump controller for the pipelined MIPS32 core.
//   Streams a program image into core memory while the core is held in
//   reset, releases the core, counts RUN cycles until HALT, then reads a
//   window of data memory back out as a valid/ready stream.
//
//   Optional feature macro: MIPS_BOOT_TIMEOUT_EN
//     defined   -> RUN is bounded by TIMEOUT cycles; on expiry timeout_o is
//                  set, the dump is skipped and the block finishes.
//     undefined -> RUN waits for HALT indefinitely; timeout_o is tied 0.
//
// Ports
//   clk1_i, reset_i        : clock (rising edge), synchronous active-high reset
//   start_i                : one-cycle start request, honoured in IDLE only
//   s_valid_i/s_ready_o    : image word handshake; s_data_i word, s_last_i final
//   mem_we_o/mem_re_o      : memory write / read strobes
//   mem_addr_o, mem_wdata_o: memory word address and write data
//   mem_rdata_i            : read data, valid the cycle after mem_re_o
//   core_rst_o             : holds core with PC=0, HALTED=1, TAKEN_BRANCH=0
//   core_halted_i          : core HALT flag
//   m_valid_o/m_ready_i    : dump stream handshake; m_data_o word, m_last_o final
//   busy_o, done_o         : not-idle flag, one-cycle completion pulse
//   timeout_o, load_trunc_o: watchdog expiry, image truncated at PROG_DEPTH
//   cycle_count_o          : RUN cycles of the last run
module mips_boot_ctrl #(
  parameter int ADDR_W     = 10,
  parameter int LOAD_BASE  = 0,
  parameter int PROG_DEPTH = 64,
  parameter int DUMP_BASE  = 198,
  parameter int DUMP_LEN   = 3,
  parameter int TIMEOUT    = 4096
) (
  input  logic              clk1_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic              s_valid_i,
  output logic              s_ready_o,
  input  logic [31:0]       s_data_i,
  input  logic              s_last_i,
  output logic              mem_we_o,
  output logic              mem_re_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  input  logic [31:0]       mem_rdata_i,
  output logic              core_rst_o,
  input  logic              core_halted_i,
  output logic              m_valid_o,
  input  logic              m_ready_i,
  output logic [31:0]       m_data_o,
  output logic              m_last_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              timeout_o,
  output logic              load_trunc_o,
  output logic [31:0]       cycle_count_o
);

  localparam int IDX_W = $clog2(PROG_DEPTH + 1);
  localparam int J_W   = $clog2(DUMP_LEN + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DREQ,
    S_DCAP,
    S_DOUT,
    S_FIN
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [J_W-1:0]   j_q, j_d;
  logic [31:0]      cnt_q, cnt_d;
  logic             first_q, first_d;   // marks the first RUN cycle
  logic             trunc_q, trunc_d;
  logic [31:0]      mdata_q, mdata_d;
`ifdef MIPS_BOOT_TIMEOUT_EN
  logic             to_q, to_d;
`endif

  logic last_word;
  assign last_word = (j_q == J_W'(DUMP_LEN - 1));

  // Next-state and output decode
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    j_d         = j_q;
    cnt_d       = cnt_q;
    first_d     = first_q;
    trunc_d     = trunc_q;
    mdata_d     = mdata_q;
`ifdef MIPS_BOOT_TIMEOUT_EN
    to_d        = to_q;
`endif
    s_ready_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_re_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    core_rst_o  = 1'b1;
    m_valid_o   = 1'b0;
    m_last_o    = 1'b0;
    busy_o      = 1'b1;
    done_o      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        busy_o = 1'b0;
        if (start_i) begin
          state_d = S_LOAD;
          idx_d   = '0;
          j_d     = '0;
          cnt_d   = '0;
          trunc_d = 1'b0;
          mdata_d = '0;
`ifdef MIPS_BOOT_TIMEOUT_EN
          to_d    = 1'b0;
`endif
        end
      end

      S_LOAD: begin
        // A word presented while reset is high is not accepted: the abort
        // must not leave a stray write behind in memory.
        s_ready_o = !reset_i;
        if (s_valid_i && !reset_i) begin
          mem_we_o    = 1'b1;
          mem_addr_o  = ADDR_W'(LOAD_BASE) + ADDR_W'(idx_q);
          mem_wdata_o = s_data_i;
          idx_d       = idx_q + 1'b1;
          if (s_last_i) begin
            state_d = S_RUN;
            first_d = 1'b1;
          end else if (idx_q == IDX_W'(PROG_DEPTH - 1)) begin
            state_d = S_RUN;
            first_d = 1'b1;
            trunc_d = 1'b1;
          end
        end
      end

      S_RUN: begin
        core_rst_o = 1'b0;
        cnt_d      = cnt_q + 32'd1;
        first_d    = 1'b0;
        // The core comes out of reset with HALTED=1; that stale flag is
        // still visible in the first RUN cycle and must not end the run.
        if (!first_q && core_halted_i) begin
          state_d = S_DREQ;
        end
`ifdef MIPS_BOOT_TIMEOUT_EN
        else if (cnt_d == 32'(TIMEOUT)) begin
          to_d    = 1'b1;
          state_d = S_FIN;
        end
`endif
      end

      S_DREQ: begin
        core_rst_o = 1'b0;
        mem_re_o   = 1'b1;
        mem_addr_o = ADDR_W'(DUMP_BASE) + ADDR_W'(j_q);
        state_d    = S_DCAP;
      end

      S_DCAP: begin
        core_rst_o = 1'b0;
        mdata_d    = mem_rdata_i;
        state_d    = S_DOUT;
      end

      S_DOUT: begin
        core_rst_o = 1'b0;
        m_valid_o  = 1'b1;
        m_last_o   = last_word;
        if (m_ready_i) begin
          if (last_word) begin
            state_d = S_FIN;
          end else begin
            j_d     = j_q + 1'b1;
            state_d = S_DREQ;
          end
        end
      end

      S_FIN: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk1_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      j_q     <= '0;
      cnt_q   <= '0;
      first_q <= 1'b0;
      trunc_q <= 1'b0;
      mdata_q <= '0;
`ifdef MIPS_BOOT_TIMEOUT_EN
      to_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      j_q     <= j_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
      trunc_q <= trunc_d;
      mdata_q <= mdata_d;
`ifdef MIPS_BOOT_TIMEOUT_EN
      to_q    <= to_d;
`endif
    end
  end

  assign m_data_o      = mdata_q;
  assign load_trunc_o  = trunc_q;
  assign cycle_count_o = cnt_q;
`ifdef MIPS_BOOT_TIMEOUT_EN
  assign timeout_o     = to_q;
`else
  assign timeout_o     = 1'b0;
`endif

endmodule

// File: tb/tb_mips_boot_ctrl.sv
// Directed bench for mips_boot_ctrl: factorial image load and dump with a
// behavioural core stub, m_ready stall, reset during LOAD, stale/held HALT,
// and (second instance, PROG_DEPTH=4, TIMEOUT=50) truncation and watchdog.
module tb_mips_boot_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance signals
  logic        reset, start, s_valid, s_last, m_ready, force_halt;
  logic [31:0] s_data;
  logic        s_ready, mem_we, mem_re, core_rst, m_valid, m_last;
  logic        busy, done, timeout, load_trunc;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata, m_data, cycle_count;
  logic [31:0] mem_rdata;
  logic        st_halt;
  int          rc;

  // Truncation / watchdog instance signals
  logic        t_start, t_s_valid, t_s_last;
  logic [31:0] t_s_data;
  logic        t_s_ready, t_mem_we, t_mem_re, t_core_rst, t_m_valid, t_m_last;
  logic        t_busy, t_done, t_timeout, t_load_trunc;
  logic [9:0]  t_mem_addr;
  logic [31:0] t_mem_wdata, t_m_data, t_cycle_count;
  logic        t_mv_seen = 1'b0;

  logic [31:0] mem [0:1023];
  int we_cnt = 0, re_cnt = 0, t_we_cnt = 0;
  int checks = 0, errors = 0;

  logic [31:0] prog [11] = '{32'h280a00c8, 32'h28020001, 32'h0e94a000,
                             32'h21430000, 32'h0e94a000, 32'h14431000,
                             32'h2c630001, 32'h0e94a000, 32'h3460fffc,
                             32'h2542fffe, 32'hfc000000};

  mips_boot_ctrl dut (
    .clk1_i(clk), .reset_i(reset), .start_i(start),
    .s_valid_i(s_valid), .s_ready_o(s_ready), .s_data_i(s_data), .s_last_i(s_last),
    .mem_we_o(mem_we), .mem_re_o(mem_re), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata),
    .core_rst_o(core_rst), .core_halted_i(st_halt | force_halt),
    .m_valid_o(m_valid), .m_ready_i(m_ready), .m_data_o(m_data), .m_last_o(m_last),
    .busy_o(busy), .done_o(done), .timeout_o(timeout), .load_trunc_o(load_trunc),
    .cycle_count_o(cycle_count)
  );

  mips_boot_ctrl #(.PROG_DEPTH(4), .TIMEOUT(50)) dut_t (
    .clk1_i(clk), .reset_i(reset), .start_i(t_start),
    .s_valid_i(t_s_valid), .s_ready_o(t_s_ready), .s_data_i(t_s_data), .s_last_i(t_s_last),
    .mem_we_o(t_mem_we), .mem_re_o(t_mem_re), .mem_addr_o(t_mem_addr),
    .mem_wdata_o(t_mem_wdata), .mem_rdata_i(32'd0),
    .core_rst_o(t_core_rst), .core_halted_i(1'b0),
    .m_valid_o(t_m_valid), .m_ready_i(1'b0), .m_data_o(t_m_data), .m_last_o(t_m_last),
    .busy_o(t_busy), .done_o(t_done), .timeout_o(t_timeout), .load_trunc_o(t_load_trunc),
    .cycle_count_o(t_cycle_count)
  );

  function automatic logic [31:0] fact(input logic [31:0] n);
    logic [31:0] r = 32'd1;
    for (int i = 2; i <= int'(n); i++) r = r * 32'(i);
    return r;
  endfunction

  // Memory plus core stub: the stub leaves reset with HALTED still 1 for a
  // cycle, runs 30 cycles, stores n! at 198 (as the factorial program would)
  // and halts.
  always @(posedge clk) begin
    if (reset) begin
      mem[198] <= 32'd0;
      mem[199] <= 32'd0;
      mem[200] <= 32'd7;
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
    if (mem_re) mem_rdata <= mem[mem_addr];
    if (reset || core_rst) begin
      st_halt <= 1'b1;
      rc      <= 0;
    end else if (rc < 30) begin
      st_halt <= 1'b0;
      rc      <= rc + 1;
      if (rc == 29) begin
        st_halt  <= 1'b1;
        mem[198] <= fact(mem[200]);
      end
    end
  end

  always @(posedge clk) begin
    if (mem_we) we_cnt <= we_cnt + 1;
    if (mem_re) re_cnt <= re_cnt + 1;
    if (t_mem_we) t_we_cnt <= t_we_cnt + 1;
    if (t_m_valid) t_mv_seen <= 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    int n, we0;
    logic [31:0] dexp [3];
    dexp[0] = 32'd5040; dexp[1] = 32'd0; dexp[2] = 32'd7;
    reset = 1'b1; start = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = '0;
    m_ready = 1'b0; force_halt = 1'b0;
    t_start = 1'b0; t_s_valid = 1'b0; t_s_last = 1'b0; t_s_data = '0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_core_rst", core_rst, 1);   chk("rst_s_ready", s_ready, 0);
    chk("rst_busy", busy, 0);           chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_re", mem_re, 0);       chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0); chk("rst_m_valid", m_valid, 0);
    chk("rst_m_last", m_last, 0);       chk("rst_done", done, 0);
    chk("rst_timeout", timeout, 0);     chk("rst_trunc", load_trunc, 0);
    chk("rst_cycles", cycle_count, 0);  chk("rst_m_data", m_data, 0);
    reset = 1'b0;

    // Factorial image load
    @(negedge clk); start = 1'b1; #1 chk("idle_busy", busy, 0);
    @(negedge clk); start = 1'b0; #1
    chk("load_s_ready", s_ready, 1); chk("load_busy", busy, 1); chk("load_core_rst", core_rst, 1);
    for (int k = 0; k < 11; k++) begin
      s_valid = 1'b1; s_data = prog[k]; s_last = (k == 10); #1;
      chk("load_we", mem_we, 1);
      chk("load_addr", mem_addr, 32'(k));
      chk("load_wdata", mem_wdata, prog[k]);
      @(negedge clk);
    end
    s_valid = 1'b0; s_last = 1'b0; #1;
    chk("run1_core_rst", core_rst, 0); chk("run1_s_ready", s_ready, 0);
    chk("run1_trunc", load_trunc, 0);  chk("run1_we", mem_we, 0);
    chk("img_we_cnt", we_cnt, 11);
    chk("img_word0", mem[0], 32'h280a00c8); chk("img_word10", mem[10], 32'hfc000000);

    // Dump word 0 with a 20-cycle m_ready stall
    n = 0;
    while (!m_valid && n < 200) begin @(negedge clk); n++; end
    chk("dump0_seen", m_valid, 1);
    chk("run_cycles", cycle_count, 31);
    repeat (20) begin
      chk("stall_valid", m_valid, 1); chk("stall_data", m_data, 32'd5040);
      chk("stall_last", m_last, 0);
      @(negedge clk);
    end
    chk("stall_re_cnt", re_cnt, 1);
    m_ready = 1'b1; @(negedge clk); m_ready = 1'b0;
    for (int w = 1; w < 3; w++) begin
      n = 0;
      while (!m_valid && n < 50) begin @(negedge clk); n++; end
      chk("dump_seen", m_valid, 1);
      chk("dump_lat", n, 2);
      chk("dump_data", m_data, dexp[w]);
      chk("dump_last", m_last, (w == 2) ? 32'd1 : 32'd0);
      m_ready = 1'b1; @(negedge clk); m_ready = 1'b0;
    end
    #1 chk("fin_done", done, 1); chk("fin_core_rst", core_rst, 1); chk("fin_busy", busy, 1);
    @(negedge clk);
    chk("post_done", done, 0); chk("post_busy", busy, 0);
    chk("post_re_cnt", re_cnt, 3); chk("post_cycles", cycle_count, 31);

    // Reset in the 3rd LOAD cycle
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    we0 = we_cnt;
    s_valid = 1'b1; s_last = 1'b0; s_data = 32'h11111111; @(negedge clk);
    s_data = 32'h22222222; @(negedge clk);
    s_data = 32'h33333333; reset = 1'b1; @(negedge clk);
    reset = 1'b0; s_valid = 1'b0; #1;
    chk("abort_busy", busy, 0); chk("abort_core_rst", core_rst, 1);
    chk("abort_s_ready", s_ready, 0); chk("abort_we_cnt", we_cnt, 32'(we0 + 2));
    chk("abort_dropped", mem[2], 32'h0e94a000);

    // Restart at LOAD_BASE with HALTED held high into RUN
    force_halt = 1'b1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    s_valid = 1'b1; s_data = 32'hfc000000; s_last = 1'b1; #1;
    chk("restart_we", mem_we, 1); chk("restart_addr", mem_addr, 0);
    @(negedge clk); s_valid = 1'b0; s_last = 1'b0; #1;
    chk("held_r1_core_rst", core_rst, 0); chk("held_r1_re", mem_re, 0);
    @(negedge clk); chk("held_r2_re", mem_re, 0);
    @(negedge clk);
    chk("held_dreq_re", mem_re, 1); chk("held_dreq_addr", mem_addr, 198);
    chk("held_cycles", cycle_count, 2);
    m_ready = 1'b1; n = 0;
    while (!done && n < 50) begin @(negedge clk); n++; end
    chk("held_done", done, 1); chk("held_cycles_fin", cycle_count, 2);
    m_ready = 1'b0; force_halt = 1'b0;

    // Truncation: PROG_DEPTH=4, six words, no s_last
    @(negedge clk); t_start = 1'b1;
    @(negedge clk); t_start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      t_s_valid = 1'b1; t_s_data = 32'h1000ffff; t_s_last = 1'b0; #1;
      if (k < 4) begin
        chk("trunc_we", t_mem_we, 1); chk("trunc_addr", t_mem_addr, 32'(k));
        chk("trunc_ready", t_s_ready, 1);
      end else begin
        chk("trunc_ready_low", t_s_ready, 0); chk("trunc_we_low", t_mem_we, 0);
      end
      @(negedge clk);
    end
    t_s_valid = 1'b0;
    chk("trunc_flag", t_load_trunc, 1); chk("trunc_we_cnt", t_we_cnt, 4);

`ifdef MIPS_BOOT_TIMEOUT_EN
    n = 0;
    while (!t_done && n < 200) begin @(negedge clk); n++; end
    chk("wd_done", t_done, 1); chk("wd_timeout", t_timeout, 1);
    chk("wd_cycles", t_cycle_count, 50); chk("wd_core_rst", t_core_rst, 1);
    chk("wd_no_mvalid", t_mv_seen, 0);
    @(negedge clk);
    chk("wd_post_done", t_done, 0); chk("wd_post_core_rst", t_core_rst, 1);
    chk("wd_post_timeout", t_timeout, 1);
`else
    repeat (60) @(negedge clk);
    chk("nowd_busy", t_busy, 1); chk("nowd_timeout", t_timeout, 0);
    chk("nowd_core_rst", t_core_rst, 0); chk("nowd_cycles", t_cycle_count, 62);
    chk("nowd_no_mvalid", t_mv_seen, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
